mem_region_decoder: RTL

//  Parametrised, registered address decoder between the MIPS32 core's load/store unit and data memory.

---
 rtl/mem_region_decoder_pkg.sv | 54 +++++
 rtl/mem_region_match.sv | 23 ++
 rtl/mem_region_decoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_region_decoder_pkg.sv
// rtl/mem_region_decoder_pkg.sv - shared size/cause codes, default windows and access helpers
package mem_region_decoder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_UNMAPPED   = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;
  localparam logic [1:0] CAUSE_BAD_SIZE   = 2'd3;

  localparam logic [31:0] DEF_GLB_BASE  = 32'h1001_0000;
  localparam int unsigned DEF_GLB_WORDS = 1024;
  localparam int unsigned DEF_GLB_PBASE = 0;
  localparam logic [31:0] DEF_STK_BASE  = 32'h7FFF_EFFC;
  localparam int unsigned DEF_STK_WORDS = 1024;
  localparam int unsigned DEF_STK_PBASE = 1024;
  localparam logic [31:0] DEF_IO_BASE   = 32'hFFFF_0000;
  localparam int unsigned DEF_IO_WORDS  = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FAULT = 1'b1
  } fault_state_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lsb;
      SIZE_HALF: be = 4'b0011 << lsb;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Highest-priority cause wins: bad size, then alignment, then mapping.
  function automatic logic [1:0] access_cause(input logic [1:0] size, input logic [1:0] lsb,
                                              input logic mapped);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (size == SIZE_RSVD)
      cause = CAUSE_BAD_SIZE;
    else if ((size == SIZE_HALF && lsb[0]) || (size == SIZE_WORD && lsb != 2'b00))
      cause = CAUSE_MISALIGNED;
    else if (!mapped)
      cause = CAUSE_UNMAPPED;
    return cause;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// rtl/mem_region_match.sv - combinational window hit and word-address translation for one region
module mem_region_match #(
  parameter logic [31:0] BASE    = 32'h1001_0000,
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned PBASE   = 0,
  parameter int          PADDR_W = 11
) (
  input  logic [31:0]        vaddr,
  output logic               hit,
  output logic [PADDR_W-1:0] paddr
);

  // 33-bit bounds so a window ending at 2^32 never wraps back to zero.
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + (33'(WORDS) << 2);

  logic [31:0] offset;

  assign hit    = ({1'b0, vaddr} >= LO) && ({1'b0, vaddr} < HI);
  assign offset = vaddr - BASE;
  assign paddr  = PADDR_W'(PBASE) + PADDR_W'(offset >> 2);

endmodule

// File: rtl/mem_region_decoder.sv
// rtl/mem_region_decoder.sv - registered load/store address decoder with sticky fault capture
module mem_region_decoder
  import mem_region_decoder_pkg::*;
#(
  parameter int          PADDR_W   = 11,
  parameter logic [31:0] GLB_BASE  = DEF_GLB_BASE,
  parameter int unsigned GLB_WORDS = DEF_GLB_WORDS,
  parameter int unsigned GLB_PBASE = DEF_GLB_PBASE,
  parameter logic [31:0] STK_BASE  = DEF_STK_BASE,
  parameter int unsigned STK_WORDS = DEF_STK_WORDS,
  parameter int unsigned STK_PBASE = DEF_STK_PBASE,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter int unsigned IO_WORDS  = DEF_IO_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_vaddr,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  output logic               mem_en,
  output logic               mem_we,
  output logic [PADDR_W-1:0] mem_paddr,
  output logic [3:0]         mem_be,
  output logic               io_en,
  output logic               io_we,
  output logic [5:0]         io_addr,
  output logic [3:0]         io_be,
  output logic               fault_valid,
  output logic [1:0]         fault_cause,
  output logic [31:0]        fault_vaddr,
  output logic               fault_store,
  input  logic               fault_ack
);

  fault_state_t state_q, state_d;

  logic               glb_hit, stk_hit, io_hit;
  logic [PADDR_W-1:0] glb_paddr, stk_paddr;
  logic [5:0]         io_word;
  logic [1:0]         cause;
  logic [3:0]         be;
  logic               accept;

  mem_region_match #(.BASE(GLB_BASE), .WORDS(GLB_WORDS), .PBASE(GLB_PBASE), .PADDR_W(PADDR_W))
    u_glb (.vaddr(req_vaddr), .hit(glb_hit), .paddr(glb_paddr));

  mem_region_match #(.BASE(STK_BASE), .WORDS(STK_WORDS), .PBASE(STK_PBASE), .PADDR_W(PADDR_W))
    u_stk (.vaddr(req_vaddr), .hit(stk_hit), .paddr(stk_paddr));

  mem_region_match #(.BASE(IO_BASE), .WORDS(IO_WORDS), .PBASE(0), .PADDR_W(6))
    u_io (.vaddr(req_vaddr), .hit(io_hit), .paddr(io_word));

  assign req_ready   = !rst && (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign fault_valid = (state_q == ST_FAULT);
  assign cause       = access_cause(req_size, req_vaddr[1:0], glb_hit || stk_hit || io_hit);
  assign be          = byte_enables(req_size, req_vaddr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && cause != CAUSE_NONE) state_d = ST_FAULT;
      ST_FAULT: if (fault_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_paddr   <= '0;
      mem_be      <= 4'b0000;
      io_en       <= 1'b0;
      io_we       <= 1'b0;
      io_addr     <= 6'd0;
      io_be       <= 4'b0000;
      fault_cause <= CAUSE_NONE;
      fault_vaddr <= 32'd0;
      fault_store <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_en  <= 1'b0;
      io_en   <= 1'b0;
      if (accept) begin
        if (cause == CAUSE_NONE) begin
          // Overlapping windows resolve global first, then stack, then MMIO.
          if (glb_hit || stk_hit) begin
            mem_en    <= 1'b1;
            mem_we    <= req_write;
            mem_paddr <= glb_hit ? glb_paddr : stk_paddr;
            mem_be    <= be;
          end else begin
            io_en   <= 1'b1;
            io_we   <= req_write;
            io_addr <= io_word;
            io_be   <= be;
          end
        end else begin
          fault_cause <= cause;
          fault_vaddr <= req_vaddr;
          fault_store <= req_write;
        end
      end else if (state_q == ST_FAULT && fault_ack) begin
        fault_cause <= CAUSE_NONE;
        fault_vaddr <= 32'd0;
        fault_store <= 1'b0;
      end
    end
  end

endmodule
